treasure_result_filter: RTL

//  Downstream of the camera downsampler/edge stage. Each frame it takes the downsampler's end-of-frame counts and classifies them into a 3-bit treasure code.
//  The code is published only after STABLE_FRAMES consecutive identical frame codes.

---
 rtl/treasure_result_filter_if.sv | 24 ++
 rtl/treasure_result_filter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/treasure_result_filter_if.sv
// Camera-stage counts in, published treasure code and Arduino REQ/ACK handshake out.
// The DUT sits on the slave side; the frame source / Arduino side is the master.
interface treasure_result_filter_if;
   logic        frame_done;
   logic [15:0] num_red;
   logic [15:0] num_blue;
   logic [15:0] num_neg;
   logic [15:0] num_pos;
   logic [15:0] num_straight;
   logic        ard_ack;
   logic [2:0]  result;
   logic        result_valid;
   logic [7:0]  led;

   modport master (
      output frame_done, num_red, num_blue, num_neg, num_pos, num_straight, ard_ack,
      input  result, result_valid, led
   );

   modport slave (
      input  frame_done, num_red, num_blue, num_neg, num_pos, num_straight, ard_ack,
      output result, result_valid, led
   );
endinterface

// File: rtl/treasure_result_filter.sv
// Classifies per-frame edge/colour counts into a 3-bit treasure code, debounces it over
// STABLE_FRAMES agreeing frames and presents each new code to the Arduino via REQ/ACK.
module treasure_result_filter #(
   parameter int unsigned COLOR_MIN     = 6,
   parameter int unsigned SHAPE_MIN     = 6,
   parameter int unsigned SPLIT_MIN     = 3,
   parameter int unsigned STABLE_FRAMES = 4,
   parameter int unsigned ACK_TIMEOUT   = 1000000
) (
   input  logic                    clk,
   input  logic                    reset_n,
   treasure_result_filter_if.slave bus
);

   localparam int TW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 2;

   localparam logic [15:0]   COLOR_MIN_W = 16'(COLOR_MIN);
   localparam logic [15:0]   SHAPE_MIN_W = 16'(SHAPE_MIN);
   localparam logic [15:0]   SPLIT_MIN_W = 16'(SPLIT_MIN);
   localparam logic [3:0]    STABLE_W    = 4'(STABLE_FRAMES);
   localparam logic [TW-1:0] TMO_LAST    = TW'(ACK_TIMEOUT - 1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] PRESENT = 2'd1;
   localparam logic [1:0] RELEASE = 2'd2;

   logic          is_red;
   logic          is_blue;
   logic [1:0]    shape;
   logic [2:0]    frame_code;

   logic [2:0]    cand_reg;
   logic [3:0]    agree_reg;
   logic [1:0]    ack_sync_reg;
   logic          ack_s;

   logic [1:0]    state_reg,  state_next;
   logic [2:0]    result_reg, result_next;
   logic          valid_reg,  valid_next;
   logic [TW-1:0] tmo_reg,    tmo_next;
   logic          publish;
   logic [7:0]    led_w;

   always_comb begin
      is_red  = (bus.num_red  >= COLOR_MIN_W);
      is_blue = (bus.num_blue >= COLOR_MIN_W);
      shape   = 2'b00;
      if ((bus.num_neg >= SPLIT_MIN_W) && (bus.num_pos >= SPLIT_MIN_W))
         shape = 2'b11;
      else if (bus.num_straight >= SHAPE_MIN_W)
         shape = 2'b01;
      else if (bus.num_neg >= SHAPE_MIN_W)
         shape = 2'b10;
      // Red takes priority when both colours clear the threshold.
      frame_code = ((is_red || is_blue) && (shape != 2'b00)) ? {is_red, shape} : 3'b000;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cand_reg  <= 3'b000;
         agree_reg <= 4'd0;
      end else if (bus.frame_done) begin
         if (frame_code == cand_reg) begin
            if (agree_reg < STABLE_W)
               agree_reg <= agree_reg + 4'd1;
         end else begin
            cand_reg  <= frame_code;
            agree_reg <= 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         ack_sync_reg <= 2'b00;
      else
         ack_sync_reg <= {ack_sync_reg[0], bus.ard_ack};
   end

   assign ack_s   = ack_sync_reg[1];
   assign publish = (agree_reg == STABLE_W) && (cand_reg != result_reg);

   always_comb begin
      state_next  = state_reg;
      result_next = result_reg;
      valid_next  = valid_reg;
      tmo_next    = tmo_reg;
      case (state_reg)
         IDLE: begin
            if (publish) begin
               result_next = cand_reg;
               valid_next  = 1'b1;
               tmo_next    = '0;
               state_next  = PRESENT;
            end
         end
         PRESENT: begin
            if (ack_s) begin
               valid_next = 1'b0;
               state_next = RELEASE;
            end else if (tmo_reg == TMO_LAST) begin
               // Abandon but keep RESULT so the same code is not re-presented.
               valid_next = 1'b0;
               state_next = IDLE;
            end else begin
               tmo_next = tmo_reg + TW'(1);
            end
         end
         RELEASE: begin
            if (!ack_s)
               state_next = IDLE;
         end
         default: begin
            valid_next = 1'b0;
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg  <= IDLE;
         result_reg <= 3'b000;
         valid_reg  <= 1'b0;
         tmo_reg    <= '0;
      end else begin
         state_reg  <= state_next;
         result_reg <= result_next;
         valid_reg  <= valid_next;
         tmo_reg    <= tmo_next;
      end
   end

   assign led_w[0] = 1'b0;
   generate
      for (genvar gi = 1; gi < 8; gi++) begin : g_led
         assign led_w[gi] = (result_reg == 3'(gi));
      end
   endgenerate

   assign bus.result       = result_reg;
   assign bus.result_valid = valid_reg;
   assign bus.led          = led_w;

endmodule
